// File: rtl/mem_bank_pkg.sv
// Shared types for the memory bank controller and its read-return pipeline.
package mem_bank_pkg;

    // Widest bank index ever needed (up to 8 banks).
    localparam int unsigned MAX_BANK_W = 3;

    localparam logic MODE_DIRECT   = 1'b0;
    localparam logic MODE_PINGPONG = 1'b1;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        SWAP
    } ctrl_state_t;

    // One in-flight read: which bank it went to and whether that bank was out of range.
    typedef struct packed {
        logic                  valid;
        logic [MAX_BANK_W-1:0] bank;
        logic                  oob;
    } rd_tag_t;

endpackage

// File: rtl/mem_rd_pipe.sv
// RD_LAT-deep tag shift register that follows each read to its data-return cycle.
module mem_rd_pipe
    import mem_bank_pkg::*;
#(
    parameter int unsigned RD_LAT = 1
) (
    input  logic    clk,
    input  logic    rst_n,
    input  rd_tag_t in_tag,
    output rd_tag_t out_tag,
    output logic    any_valid
);

    rd_tag_t stage_q [RD_LAT];

    // Shift tags one stage per cycle; reset discards everything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < RD_LAT; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= in_tag;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    // Reads still in flight after this cycle; the output stage retires now.
    always_comb begin
        any_valid = 1'b0;
        for (int unsigned i = 0; i + 1 < RD_LAT; i++) begin
            any_valid = any_valid | stage_q[i].valid;
        end
    end

    assign out_tag = stage_q[RD_LAT-1];

endmodule

// File: rtl/mem_bank_ctrl.sv
// Request-port to multi-bank BRAM strobe controller with direct and ping-pong modes.
module mem_bank_ctrl
    import mem_bank_pkg::*;
#(
    parameter  int unsigned NUM_BANKS = 2,
    parameter  int unsigned ADDR_W    = 10,
    parameter  int unsigned DATA_W    = 32,
    parameter  int unsigned RD_LAT    = 1,
    localparam int unsigned BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        mode,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_we,
    input  logic [BANK_W-1:0]           req_bank,
    input  logic [ADDR_W-1:0]           req_addr,
    input  logic [DATA_W-1:0]           req_wdata,
    input  logic                        swap_req,
    output logic                        swap_done,
    output logic [BANK_W-1:0]           wr_bank,
    output logic [NUM_BANKS-1:0]        bank_ena,
    output logic [NUM_BANKS-1:0]        bank_wea,
    output logic [ADDR_W-1:0]           bank_addr,
    output logic [DATA_W-1:0]           bank_wdata,
    input  logic [NUM_BANKS*DATA_W-1:0] bank_rdata,
    output logic                        rsp_valid,
    output logic [DATA_W-1:0]           rsp_rdata,
    output logic                        err_oob
);

    ctrl_state_t       state_q, state_d;
    logic [BANK_W-1:0] wr_bank_q;
    logic              swap_done_q;
    logic              err_oob_q;
    logic              swap_fire;
    logic              accept;
    logic              oob;
    logic [BANK_W-1:0] rd_bank;
    logic [BANK_W-1:0] target;
    rd_tag_t           pipe_in;
    rd_tag_t           pipe_out;
    logic              pipe_busy;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake: requests stall from swap request until the bank flips.
    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        swap_fire = 1'b0;
        case (state_q)
            RUN: begin
                req_ready = 1'b1;
                if (swap_req && (mode == MODE_PINGPONG)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!pipe_busy) begin
                    state_d = SWAP;
                end
            end
            SWAP: begin
                swap_fire = 1'b1;
                state_d   = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    // Bank selection for the request presented this cycle.
    always_comb begin
        accept  = req_valid & req_ready;
        rd_bank = (wr_bank_q == '0) ? BANK_W'(NUM_BANKS - 1) : wr_bank_q - BANK_W'(1);
        if (mode == MODE_PINGPONG) begin
            target = req_we ? wr_bank_q : rd_bank;
        end else begin
            target = req_bank;
        end
        oob = (32'(target) >= NUM_BANKS);
    end

    // One-hot strobes only for an accepted, in-range request.
    always_comb begin
        bank_ena = '0;
        bank_wea = '0;
        for (int unsigned i = 0; i < NUM_BANKS; i++) begin
            if (accept && !oob && (32'(target) == i)) begin
                bank_ena[i] = 1'b1;
                bank_wea[i] = req_we;
            end
        end
    end

    // Tag for the read entering the return pipeline.
    always_comb begin
        pipe_in       = '0;
        pipe_in.valid = accept & ~req_we;
        pipe_in.bank  = MAX_BANK_W'(target);
        pipe_in.oob   = oob;
    end

    mem_rd_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_tag    (pipe_in),
        .out_tag   (pipe_out),
        .any_valid (pipe_busy)
    );

    // Steer the tagged bank's data back; out-of-range reads return zero.
    always_comb begin
        rsp_rdata = '0;
        for (int unsigned i = 0; i < NUM_BANKS; i++) begin
            if (pipe_out.valid && !pipe_out.oob && (32'(pipe_out.bank) == i)) begin
                rsp_rdata = bank_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Write-bank pointer and registered status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank_q   <= '0;
            swap_done_q <= 1'b0;
            err_oob_q   <= 1'b0;
        end else begin
            swap_done_q <= swap_fire;
            err_oob_q   <= accept & oob;
            if (swap_fire) begin
                wr_bank_q <= (32'(wr_bank_q) == NUM_BANKS - 1) ? '0 : wr_bank_q + BANK_W'(1);
            end
        end
    end

    assign wr_bank    = wr_bank_q;
    assign swap_done  = swap_done_q;
    assign err_oob    = err_oob_q;
    assign rsp_valid  = pipe_out.valid;
    assign bank_addr  = req_addr;
    assign bank_wdata = req_wdata;

endmodule

// File: doc/mem_bank_ctrl.md
Name: mem_bank_ctrl

Overview:
- Parametrised bank controller that turns a single valid/ready memory request port into per-bank enable and write-enable strobes for NUM_BANKS block RAMs.
- Tracks each read through a RD_LAT-deep return pipeline and steers the correct bank's read data back as a response.
- Supports a direct mode, where the request selects the bank, and a ping-pong mode, where writes fill one bank while reads drain the previous one, with a drained, handshaked bank swap.
- Sits between the datapath/control unit and the BRAM instances; it replaces the fixed two-bank enable decoding.

Parameters:
- NUM_BANKS, 2, number of BRAM banks (2..8).
- ADDR_W, 10, per-bank word address width.
- DATA_W, 32, data word width.
- RD_LAT, 1, BRAM read latency in cycles (1..4).
- BANK_W, $clog2(NUM_BANKS) (min 1), derived bank index width; not overridable.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mode  in  1  0 = direct, 1 = ping-pong.
- req_valid  in  1  request present.
- req_ready  out  1  request can be accepted this cycle.
- req_we  in  1  1 = write, 0 = read.
- req_bank  in  BANK_W  target bank (direct mode only).
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- swap_req  in  1  single-cycle pulse requesting a ping-pong swap.
- swap_done  out  1  single-cycle pulse when the swap completes.
- wr_bank  out  BANK_W  current ping-pong write bank.
- bank_ena  out  NUM_BANKS  per-bank enable.
- bank_wea  out  NUM_BANKS  per-bank write enable.
- bank_addr  out  ADDR_W  shared address to all banks.
- bank_wdata  out  DATA_W  shared write data to all banks.
- bank_rdata  in  NUM_BANKS*DATA_W  flattened bank read data; bank i at [i*DATA_W +: DATA_W].
- rsp_valid  out  1  read response valid.
- rsp_rdata  out  DATA_W  read response data.
- err_oob  out  1  pulse: out-of-range bank accessed.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - FSM enters RUN; wr_bank = 0.
  - Read pipeline is cleared; rsp_valid, swap_done and err_oob are 0.
  - Outstanding reads are discarded and never produce rsp_valid.
- Accept condition: req_valid & req_ready.
- FSM states and transitions:
  - RUN: req_ready = 1.
  - On swap_req with mode = 1, go to DRAIN. Any request accepted in that same cycle uses the old wr_bank.
  - swap_req with mode = 0 is ignored.
  - DRAIN: req_ready = 0. Stay until no read pipeline stage is valid, then go to SWAP.
  - SWAP, one cycle: req_ready = 0; wr_bank <= (wr_bank+1) mod NUM_BANKS; swap_done = 1 next cycle (registered); return to RUN.
  - swap_req arriving in DRAIN or SWAP is ignored.
- Bank target, computed per accepted request from the mode sampled that cycle:
  - Direct mode: target = req_bank.
  - Ping-pong writes: target = wr_bank.
  - Ping-pong reads: target = (wr_bank + NUM_BANKS - 1) mod NUM_BANKS.
- Strobes (combinational from accept):
  - Accepted request: bank_ena is one-hot on the target; bank_wea = bank_ena & req_we.
  - No accept: both vectors are all zero. There is no default-enabled bank.
  - bank_addr and bank_wdata pass through req_addr and req_wdata.
- Out of range (target >= NUM_BANKS, non-power-of-2 only):
  - No bank is enabled.
  - err_oob pulses 1 in the cycle after the accept.
  - A read still produces a response, with rsp_rdata = 0.
- Read pipeline:
  - RD_LAT stages, each holding {valid, bank index, oob}.
  - A read accepted in cycle T gives rsp_valid = 1 in cycle T+RD_LAT.
  - rsp_rdata is the combinational mux of bank_rdata by the stage-RD_LAT bank index.
  - Writes enter no pipeline stage.
  - Back-to-back reads at full throughput, one per cycle, with no bubbles.
  - A mode change with reads in flight is legal; each read returns from the bank it was issued to.
- NUM_BANKS = 1 degenerates correctly: ping-pong reads and writes target bank 0; a swap keeps wr_bank = 0 but still drains and pulses swap_done.

Decomposition:
- Package mem_bank_pkg:
  - ctrl_state_t enum {RUN, DRAIN, SWAP}.
  - MODE_DIRECT = 1'b0, MODE_PINGPONG = 1'b1.
  - rd_tag_t struct {valid, bank, oob}.
- One sub-module, mem_rd_pipe:
  - Parametrised RD_LAT shift register of rd_tag_t with async clear.
  - Exposes the last stage and an any_valid flag, used for DRAIN exit.

Test Plan:
- Direct writes: mode = 0, NUM_BANKS = 4, write bank 2 at addr 0x05, data 0xDEADBEEF -> that cycle bank_ena = 0100, bank_wea = 0100, bank_addr = 0x05; the next idle cycle gives ena = 0000.
- Read latency: RD_LAT = 3, reads to banks 0, 1, 3 in consecutive cycles T..T+2, with a model BRAM returning {bank, addr} -> rsp_valid high at T+3..T+5 with matching data in issue order.
- Ping-pong swap: mode = 1, NUM_BANKS = 2, write to wr_bank 0, then one read with RD_LAT = 2 and swap_req in the same cycle as that read -> read targets bank 1; DRAIN holds req_ready = 0 for 2 cycles; SWAP; swap_done pulses once; wr_bank = 1; the next read targets bank 0.
- Out of range: NUM_BANKS = 3, read req_bank = 3 -> bank_ena = 000, err_oob pulses 1 cycle later, rsp_valid after RD_LAT with rsp_rdata = 0.
- Reset mid-flight: RD_LAT = 4, two reads issued, rst_n low for 1 cycle at T+1 -> all outputs 0 immediately, no rsp_valid ever for those reads, wr_bank = 0, FSM in RUN.
- Ignored swap: mode = 0 swap_req -> req_ready stays 1, no swap_done; a second swap_req during DRAIN -> exactly one swap_done and wr_bank advances by 1.
